// File: rtl/reg_port_master.sv
// Requester-side sequencer for the register file's enable/finished handshake.
// One transaction at a time; write-back wins over operand reads.
module reg_port_master #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        rd_req_valid,
  output logic        rd_req_ready,
  input  logic        use_rs,
  input  logic        use_rt,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic        rd_resp_valid,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        wb_done,
  output logic        err,
  output logic        re1,
  output logic        re2,
  output logic        we,
  output logic [4:0]  read_addr1,
  output logic [4:0]  read_addr2,
  output logic [4:0]  write_addr,
  output logic [31:0] write_data,
  input  logic [31:0] read_data1,
  input  logic [31:0] read_data2,
  input  logic        read_finished,
  input  logic        write_finished
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        re1_q, re1_d, re2_q, re2_d, we_q, we_d;
  logic [4:0]  read_addr1_q, read_addr1_d, read_addr2_q, read_addr2_d;
  logic [4:0]  write_addr_q, write_addr_d;
  logic [31:0] write_data_q, write_data_d;
  logic [31:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d;
  logic        rd_resp_valid_q, rd_resp_valid_d, wb_done_q, wb_done_d;
  logic        err_q, err_d;

  assign rd_req_ready  = (state_q == IDLE) && !wb_valid;
  assign wb_ready      = (state_q == IDLE);
  assign re1           = re1_q;
  assign re2           = re2_q;
  assign we            = we_q;
  assign read_addr1    = read_addr1_q;
  assign read_addr2    = read_addr2_q;
  assign write_addr    = write_addr_q;
  assign write_data    = write_data_q;
  assign rs_data       = rs_data_q;
  assign rt_data       = rt_data_q;
  assign rd_resp_valid = rd_resp_valid_q;
  assign wb_done       = wb_done_q;
  assign err           = err_q;

  // Next-state, registered enables and response generation.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    re1_d           = re1_q;
    re2_d           = re2_q;
    we_d            = we_q;
    read_addr1_d    = read_addr1_q;
    read_addr2_d    = read_addr2_q;
    write_addr_d    = write_addr_q;
    write_data_d    = write_data_q;
    rs_data_d       = rs_data_q;
    rt_data_d       = rt_data_q;
    rd_resp_valid_d = 1'b0;
    wb_done_d       = 1'b0;
    err_d           = err_q;

    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (wb_valid) begin
          write_addr_d = wb_addr;
          write_data_d = wb_data;
          if (wb_addr == 5'd0) begin
            wb_done_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            state_d = WRITE;
          end
        end else if (rd_req_valid) begin
          read_addr1_d = rs_addr;
          read_addr2_d = rt_addr;
          if (!use_rs && !use_rt) begin
            rd_resp_valid_d = 1'b1;
            rs_data_d       = 32'd0;
            rt_data_d       = 32'd0;
          end else begin
            re1_d   = use_rs;
            re2_d   = use_rt;
            state_d = READ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        // The latched use flags live in re1_q/re2_q for the whole READ.
        if (read_finished) begin
          rs_data_d       = re1_q ? read_data1 : 32'd0;
          rt_data_d       = re2_q ? read_data2 : 32'd0;
          rd_resp_valid_d = 1'b1;
          re1_d           = 1'b0;
          re2_d           = 1'b0;
          state_d         = GAP;
        end else if (cnt_q + 8'd1 == TIMEOUT_C) begin
          err_d           = 1'b1;
          rs_data_d       = 32'd0;
          rt_data_d       = 32'd0;
          rd_resp_valid_d = 1'b1;
          re1_d           = 1'b0;
          re2_d           = 1'b0;
          state_d         = GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WRITE: begin
        if (write_finished) begin
          wb_done_d = 1'b1;
          we_d      = 1'b0;
          state_d   = GAP;
        end else if (cnt_q + 8'd1 == TIMEOUT_C) begin
          err_d     = 1'b1;
          wb_done_d = 1'b1;
          we_d      = 1'b0;
          state_d   = GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        // One idle cycle lets the register file drop its finished flags.
        re1_d   = 1'b0;
        re2_d   = 1'b0;
        we_d    = 1'b0;
        state_d = IDLE;
      end
      default: begin
        re1_d   = 1'b0;
        re2_d   = 1'b0;
        we_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered output flops with asynchronous clear.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q         <= IDLE;
      cnt_q           <= 8'd0;
      re1_q           <= 1'b0;
      re2_q           <= 1'b0;
      we_q            <= 1'b0;
      read_addr1_q    <= 5'd0;
      read_addr2_q    <= 5'd0;
      write_addr_q    <= 5'd0;
      write_data_q    <= 32'd0;
      rs_data_q       <= 32'd0;
      rt_data_q       <= 32'd0;
      rd_resp_valid_q <= 1'b0;
      wb_done_q       <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      re1_q           <= re1_d;
      re2_q           <= re2_d;
      we_q            <= we_d;
      read_addr1_q    <= read_addr1_d;
      read_addr2_q    <= read_addr2_d;
      write_addr_q    <= write_addr_d;
      write_data_q    <= write_data_d;
      rs_data_q       <= rs_data_d;
      rt_data_q       <= rt_data_d;
      rd_resp_valid_q <= rd_resp_valid_d;
      wb_done_q       <= wb_done_d;
      err_q           <= err_d;
    end
  end

endmodule

// File: tb/tb_reg_port_master.sv
// Directed bench for reg_port_master with a small behavioural register file:
// reads answer on the falling edge, writes land on the rising edge.
module tb_reg_port_master;

  logic        clk = 1'b0;
  logic        clr;
  logic        rd_req_valid, use_rs, use_rt, wb_valid;
  logic [4:0]  rs_addr, rt_addr, wb_addr;
  logic [31:0] wb_data;
  logic        rd_req_ready, rd_resp_valid, wb_ready, wb_done, err;
  logic [31:0] rs_data, rt_data;
  logic        re1, re2, we;
  logic [4:0]  read_addr1, read_addr2, write_addr;
  logic [31:0] write_data;
  logic [31:0] read_data1 = 32'h0, read_data2 = 32'h0;
  logic        read_finished = 1'b0, write_finished = 1'b0;
  logic        hold_wf;
  logic [31:0] mem [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_port_master #(.TIMEOUT(4)) dut (
    .clk(clk), .clr(clr),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .use_rs(use_rs), .use_rt(use_rt), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_resp_valid(rd_resp_valid), .rs_data(rs_data), .rt_data(rt_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_done(wb_done), .err(err),
    .re1(re1), .re2(re2), .we(we),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .write_addr(write_addr), .write_data(write_data),
    .read_data1(read_data1), .read_data2(read_data2),
    .read_finished(read_finished), .write_finished(write_finished)
  );

  // Register file read port: responds half a cycle after the enables.
  always @(negedge clk) begin
    read_finished <= re1 | re2;
    read_data1    <= mem[read_addr1];
    read_data2    <= mem[read_addr2];
  end

  // Register file write port and preload while clr is held.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      mem[5] <= 32'h11111111;
      mem[7] <= 32'h22222222;
      write_finished <= 1'b0;
    end else begin
      if (we) mem[write_addr] <= write_data;
      write_finished <= we & ~hold_wf;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++; if (re1 !== 1'b0 || re2 !== 1'b0 || we !== 1'b0) begin errors++; $display("FAIL reset_enables got %b%b%b want 000", re1, re2, we); end
    checks++; if (rd_resp_valid !== 1'b0 || wb_done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b%b want 000", rd_resp_valid, wb_done, err); end
    checks++; if (rs_data !== 32'h0 || rt_data !== 32'h0 || write_data !== 32'h0 || write_addr !== 5'd0 || read_addr1 !== 5'd0 || read_addr2 !== 5'd0) begin errors++; $display("FAIL reset_data got %h %h %h want zeros", rs_data, rt_data, write_data); end
    checks++; if (rd_req_ready !== 1'b1 || wb_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b%b want 11", rd_req_ready, wb_ready); end
  endtask

  task automatic test_read_both;
    rd_req_valid = 1'b1; use_rs = 1'b1; use_rt = 1'b1; rs_addr = 5'd5; rt_addr = 5'd7;
    tick;
    rd_req_valid = 1'b0;
    checks++; if (re1 !== 1'b1 || re2 !== 1'b1 || read_addr1 !== 5'd5 || read_addr2 !== 5'd7) begin errors++; $display("FAIL rd_enables got re=%b%b a=%0d,%0d want 11 5,7", re1, re2, read_addr1, read_addr2); end
    checks++; if (rd_resp_valid !== 1'b0) begin errors++; $display("FAIL rd_early_resp got %b want 0", rd_resp_valid); end
    tick;
    checks++; if (rd_resp_valid !== 1'b1) begin errors++; $display("FAIL rd_resp got %b want 1", rd_resp_valid); end
    checks++; if (rs_data !== 32'h11111111 || rt_data !== 32'h22222222) begin errors++; $display("FAIL rd_data got %h %h want 11111111 22222222", rs_data, rt_data); end
    checks++; if (re1 !== 1'b0 || re2 !== 1'b0 || rd_req_ready !== 1'b0) begin errors++; $display("FAIL rd_gap got re=%b%b ready=%b want 00 0", re1, re2, rd_req_ready); end
    tick;
    checks++; if (rd_resp_valid !== 1'b0 || rd_req_ready !== 1'b1 || rs_data !== 32'h11111111) begin errors++; $display("FAIL rd_after got v=%b r=%b d=%h want 0 1 11111111", rd_resp_valid, rd_req_ready, rs_data); end
  endtask

  task automatic test_write_then_read;
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'hDEADBEEF;
    tick;
    wb_valid = 1'b0;
    checks++; if (we !== 1'b1 || write_addr !== 5'd9 || write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_drive got we=%b a=%0d d=%h want 1 9 deadbeef", we, write_addr, write_data); end
    tick;
    checks++; if (wb_done !== 1'b0 || we !== 1'b1) begin errors++; $display("FAIL wr_wait got done=%b we=%b want 0 1", wb_done, we); end
    tick;
    checks++; if (wb_done !== 1'b1 || we !== 1'b0) begin errors++; $display("FAIL wr_done got done=%b we=%b want 1 0", wb_done, we); end
    tick;
    checks++; if (wb_done !== 1'b0 || wb_ready !== 1'b1) begin errors++; $display("FAIL wr_after got done=%b ready=%b want 0 1", wb_done, wb_ready); end
    rd_req_valid = 1'b1; use_rs = 1'b1; use_rt = 1'b0; rs_addr = 5'd9; rt_addr = 5'd7;
    tick;
    rd_req_valid = 1'b0;
    checks++; if (re1 !== 1'b1 || re2 !== 1'b0) begin errors++; $display("FAIL rs_only_en got %b%b want 10", re1, re2); end
    tick;
    checks++; if (rd_resp_valid !== 1'b1 || rs_data !== 32'hDEADBEEF || rt_data !== 32'h0) begin errors++; $display("FAIL rs_only_data got v=%b %h %h want 1 deadbeef 0", rd_resp_valid, rs_data, rt_data); end
    tick;
  endtask

  task automatic test_simultaneous;
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hA5A5A5A5;
    rd_req_valid = 1'b1; use_rs = 1'b1; use_rt = 1'b0; rs_addr = 5'd3;
    #1;
    checks++; if (rd_req_ready !== 1'b0 || wb_ready !== 1'b1) begin errors++; $display("FAIL sim_ready got rd=%b wb=%b want 0 1", rd_req_ready, wb_ready); end
    tick;
    wb_valid = 1'b0;
    checks++; if (we !== 1'b1 || re1 !== 1'b0 || rd_req_ready !== 1'b0) begin errors++; $display("FAIL sim_write_first got we=%b re1=%b r=%b want 1 0 0", we, re1, rd_req_ready); end
    tick; tick;
    checks++; if (wb_done !== 1'b1 || rd_req_ready !== 1'b0) begin errors++; $display("FAIL sim_wb_done got done=%b r=%b want 1 0", wb_done, rd_req_ready); end
    tick;
    checks++; if (rd_req_ready !== 1'b1 || re1 !== 1'b0) begin errors++; $display("FAIL sim_ready_after got r=%b re1=%b want 1 0", rd_req_ready, re1); end
    tick;
    rd_req_valid = 1'b0;
    checks++; if (re1 !== 1'b1 || read_addr1 !== 5'd3) begin errors++; $display("FAIL sim_read_en got re1=%b a=%0d want 1 3", re1, read_addr1); end
    tick;
    checks++; if (rd_resp_valid !== 1'b1 || rs_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL sim_read_data got v=%b %h want 1 a5a5a5a5", rd_resp_valid, rs_data); end
    tick;
  endtask

  task automatic test_x0_write;
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    tick;
    wb_valid = 1'b0;
    checks++; if (we !== 1'b0 || wb_done !== 1'b1 || wb_ready !== 1'b1) begin errors++; $display("FAIL x0_done got we=%b done=%b ready=%b want 0 1 1", we, wb_done, wb_ready); end
    tick;
    checks++; if (we !== 1'b0 || wb_done !== 1'b0) begin errors++; $display("FAIL x0_after got we=%b done=%b want 0 0", we, wb_done); end
    rd_req_valid = 1'b1; use_rs = 1'b1; use_rt = 1'b0; rs_addr = 5'd0;
    tick;
    rd_req_valid = 1'b0;
    tick;
    checks++; if (rd_resp_valid !== 1'b1 || rs_data !== 32'h0) begin errors++; $display("FAIL x0_read got v=%b %h want 1 0", rd_resp_valid, rs_data); end
    tick;
  endtask

  task automatic test_timeout;
    hold_wf = 1'b1;
    wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'h12345678;
    tick;
    wb_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick;
      checks++; if (wb_done !== 1'b0 || we !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL to_wait%0d got done=%b we=%b err=%b want 0 1 0", i, wb_done, we, err); end
    end
    tick;
    checks++; if (wb_done !== 1'b1 || err !== 1'b1 || we !== 1'b0) begin errors++; $display("FAIL to_expire got done=%b err=%b we=%b want 1 1 0", wb_done, err, we); end
    hold_wf = 1'b0;
    tick;
    rd_req_valid = 1'b1; use_rs = 1'b1; use_rt = 1'b0; rs_addr = 5'd5;
    tick;
    rd_req_valid = 1'b0;
    tick;
    checks++; if (rd_resp_valid !== 1'b1 || rs_data !== 32'h11111111 || err !== 1'b1) begin errors++; $display("FAIL to_sticky got v=%b %h err=%b want 1 11111111 1", rd_resp_valid, rs_data, err); end
    tick;
    rd_req_valid = 1'b1; use_rs = 1'b0; use_rt = 1'b0;
    tick;
    rd_req_valid = 1'b0;
    checks++; if (rd_resp_valid !== 1'b1 || rs_data !== 32'h0 || rt_data !== 32'h0 || re1 !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL empty_read got v=%b %h %h re1=%b err=%b want 1 0 0 0 1", rd_resp_valid, rs_data, rt_data, re1, err); end
    tick;
    checks++; if (rd_resp_valid !== 1'b0 || rd_req_ready !== 1'b1) begin errors++; $display("FAIL empty_after got v=%b r=%b want 0 1", rd_resp_valid, rd_req_ready); end
  endtask

  task automatic test_reset_mid;
    rd_req_valid = 1'b1; use_rs = 1'b0; use_rt = 1'b1; rt_addr = 5'd7;
    tick;
    rd_req_valid = 1'b0;
    checks++; if (re2 !== 1'b1) begin errors++; $display("FAIL rst_pre got re2=%b want 1", re2); end
    #1 clr = 1'b1;
    #1;
    checks++; if (re2 !== 1'b0 || re1 !== 1'b0 || rd_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_async got re=%b%b v=%b want 00 0", re1, re2, rd_resp_valid); end
    tick;
    clr = 1'b0;
    tick;
    checks++; if (rd_resp_valid !== 1'b0 || rd_req_ready !== 1'b1 || err !== 1'b0 || rt_data !== 32'h0) begin errors++; $display("FAIL rst_after got v=%b r=%b err=%b rt=%h want 0 1 0 0", rd_resp_valid, rd_req_ready, err, rt_data); end
  endtask

  initial begin
    clr = 1'b1; hold_wf = 1'b0;
    rd_req_valid = 1'b0; use_rs = 1'b0; use_rt = 1'b0; rs_addr = 5'd0; rt_addr = 5'd0;
    wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    tick; tick;
    test_reset;
    clr = 1'b0;
    tick;
    test_read_both;
    test_write_then_read;
    test_simultaneous;
    test_x0_write;
    test_timeout;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
